// File: rtl/gamma_pkg.sv
// Shared constants and state encoding for the frame-synchronous gamma LUT controller.
package gamma_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned LUT_DEPTH = 256;

    typedef enum logic [1:0] {
        INIT,
        LOAD,
        PEND
    } state_e;

endpackage

// File: rtl/gamma_lut_bank.sv
// One gamma curve: register array with a synchronous write port and a combinational read port.
module gamma_lut_bank #(
    parameter int unsigned DATA_W    = gamma_pkg::DATA_W,
    parameter int unsigned LUT_DEPTH = gamma_pkg::LUT_DEPTH
) (
    input  logic                         clk_i,
    input  logic                         we_i,
    input  logic [$clog2(LUT_DEPTH)-1:0] waddr_i,
    input  logic [DATA_W-1:0]            wdata_i,
    input  logic [$clog2(LUT_DEPTH)-1:0] raddr_i,
    output logic [DATA_W-1:0]            rdata_o
);

    logic [DATA_W-1:0] mem_q [LUT_DEPTH];

    // No reset on the array: the controller rewrites identity into it after every reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/gamma_lut_ctrl.sv
// Double-buffered gamma mapping: active bank maps video, shadow bank is rewritten,
// banks swap only on a vsync rising edge after a commit.
module gamma_lut_ctrl #(
    parameter int unsigned DATA_W    = gamma_pkg::DATA_W,
    parameter int unsigned LUT_DEPTH = gamma_pkg::LUT_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pre_img_vsync,
    input  logic              pre_img_hsync,
    input  logic              pre_img_valid,
    input  logic [DATA_W-1:0] pre_img_data,
    output logic              post_img_vsync,
    output logic              post_img_hsync,
    output logic              post_img_valid,
    output logic [DATA_W-1:0] post_img_gray,
    input  logic              cfg_wr_en,
    input  logic [DATA_W-1:0] cfg_wr_addr,
    input  logic [DATA_W-1:0] cfg_wr_data,
    input  logic              cfg_commit,
    output logic              cfg_ready,
    output logic              cfg_wr_drop,
    output logic              active_bank
);

    import gamma_pkg::*;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] init_cnt_q, init_cnt_d;
    logic              active_q, active_d;
    logic              drop_q, drop_d;
    logic              vs_prev_q;
    logic              vs_rise;
    logic              ready;

    logic              post_vs_q, post_hs_q, post_vld_q;
    logic [DATA_W-1:0] post_gray_q, post_gray_d;

    logic              we0, we1;
    logic [DATA_W-1:0] waddr, wdata;
    logic [DATA_W-1:0] rdata0, rdata1, rdata_sel;

    assign vs_rise = pre_img_vsync & ~vs_prev_q;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        active_d   = active_q;
        ready      = 1'b0;
        we0        = 1'b0;
        we1        = 1'b0;
        waddr      = cfg_wr_addr;
        wdata      = cfg_wr_data;
        unique case (state_q)
            INIT: begin
                we0        = 1'b1;
                we1        = 1'b1;
                waddr      = init_cnt_q;
                wdata      = init_cnt_q;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == DATA_W'(LUT_DEPTH - 1)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                ready = 1'b1;
                if (cfg_wr_en) begin
                    we0 = active_q;
                    we1 = ~active_q;
                end
                if (cfg_commit) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (vs_rise) begin
                    active_d = ~active_q;
                    state_d  = LOAD;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    assign drop_d = drop_q | ((cfg_wr_en | cfg_commit) & ~ready);

    gamma_lut_bank #(
        .DATA_W    (DATA_W),
        .LUT_DEPTH (LUT_DEPTH)
    ) u_bank0 (
        .clk_i   (clk),
        .we_i    (we0),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (pre_img_data),
        .rdata_o (rdata0)
    );

    gamma_lut_bank #(
        .DATA_W    (DATA_W),
        .LUT_DEPTH (LUT_DEPTH)
    ) u_bank1 (
        .clk_i   (clk),
        .we_i    (we1),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (pre_img_data),
        .rdata_o (rdata1)
    );

    // Select on the next bank index so the pixel sampled with the vsync rise already uses the new curve.
    assign rdata_sel   = active_d ? rdata1 : rdata0;
    assign post_gray_d = (state_q == INIT) ? pre_img_data : rdata_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            active_q    <= 1'b0;
            drop_q      <= 1'b0;
            vs_prev_q   <= 1'b0;
            post_vs_q   <= 1'b0;
            post_hs_q   <= 1'b0;
            post_vld_q  <= 1'b0;
            post_gray_q <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            active_q    <= active_d;
            drop_q      <= drop_d;
            vs_prev_q   <= pre_img_vsync;
            post_vs_q   <= pre_img_vsync;
            post_hs_q   <= pre_img_hsync;
            post_vld_q  <= pre_img_valid;
            post_gray_q <= post_gray_d;
        end
    end

    assign post_img_vsync = post_vs_q;
    assign post_img_hsync = post_hs_q;
    assign post_img_valid = post_vld_q;
    assign post_img_gray  = post_gray_q;
    assign cfg_ready      = ready;
    assign cfg_wr_drop    = drop_q;
    assign active_bank    = active_q;

endmodule
